// File: rtl/reg_file_pkg.sv
// Shared types and defaults for the integer register file with busy scoreboard.
package reg_file_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] reg_data_t;

  typedef struct packed {
    logic      en;
    reg_addr_t addr;
    reg_data_t data;
  } wr_port_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy vector with set-over-clear priority and a registered busy count.
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter  int NREGS = NREGS_DEF,
  parameter  int NWR   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NWR-1:0]          wr_en,
  input  logic [NWR-1:0][AW-1:0]  wr_addr,
  input  logic                    issue_en,
  input  logic [AW-1:0]           issue_rd,
  output logic [NREGS-1:0]        busy_o,
  output logic [AW:0]             busy_count
);

  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW:0]      count_q, count_d;

  function automatic logic [AW:0] popcount(input logic [NREGS-1:0] v);
    logic [AW:0] c;
    c = '0;
    for (int i = 0; i < NREGS; i++) begin
      c = c + {{AW{1'b0}}, v[i]};
    end
    return c;
  endfunction

  // Clears first, then the issue set: the issuing instruction is younger.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NWR; i++) begin
      if (wr_en[i]) begin
        busy_d[wr_addr[i]] = 1'b0;
      end
    end
    if (issue_en && (issue_rd != '0)) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
    count_d   = popcount(busy_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign busy_o     = busy_q;
  assign busy_count = count_q;

endmodule

// File: rtl/reg_file_sb.sv
// Multi-port register file (x0 hardwired to zero) with in-flight destination tracking.
// Define REG_FILE_SB_BYPASS_EN to forward same-cycle writes onto the read ports.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEF,
  parameter  int NREGS = NREGS_DEF,
  parameter  int NRD   = 2,
  parameter  int NWR   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NRD-1:0][AW-1:0]       rd_addr,
  output logic [NRD-1:0][XLEN-1:0]     rd_data,
  output logic [NRD-1:0]               rd_busy,
  input  logic [NWR-1:0]               wr_en,
  input  logic [NWR-1:0][AW-1:0]       wr_addr,
  input  logic [NWR-1:0][XLEN-1:0]     wr_data,
  input  logic                         issue_en,
  input  logic [AW-1:0]                issue_rd,
  output logic [AW:0]                  busy_count
);

  logic [NREGS-1:0][XLEN-1:0] regs_q, regs_d;
  logic [NREGS-1:0]           busy;

  reg_scoreboard #(
    .NREGS (NREGS),
    .NWR   (NWR)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .issue_en   (issue_en),
    .issue_rd   (issue_rd),
    .busy_o     (busy),
    .busy_count (busy_count)
  );

  // Ascending port order lets the highest-index port overwrite earlier ones.
  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NWR; i++) begin
      if (wr_en[i] && (wr_addr[i] != '0)) begin
        regs_d[wr_addr[i]] = wr_data[i];
      end
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    for (int j = 0; j < NRD; j++) begin
      rd_data[j] = regs_q[rd_addr[j]];
      rd_busy[j] = busy[rd_addr[j]];
`ifdef REG_FILE_SB_BYPASS_EN
      // Forwarding is suppressed in reset so the ports read zero throughout.
      if (!rst && (rd_addr[j] != '0)) begin
        for (int i = 0; i < NWR; i++) begin
          if (wr_en[i] && (wr_addr[i] == rd_addr[j])) begin
            rd_data[j] = wr_data[i];
            rd_busy[j] = issue_en && (issue_rd == rd_addr[j]);
          end
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard-style bench for reg_file_sb: the driver queues expectations, a negedge monitor checks them.
module tb_reg_file_sb;

  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int NRD = 2;
  localparam int NWR = 2;
  localparam int AW = 5;

  localparam int K_DATA  = 0;
  localparam int K_BUSY  = 1;
  localparam int K_COUNT = 2;

  logic                     clk;
  logic                     rst;
  logic [NRD-1:0][AW-1:0]   rd_addr;
  logic [NRD-1:0][XLEN-1:0] rd_data;
  logic [NRD-1:0]           rd_busy;
  logic [NWR-1:0]           wr_en;
  logic [NWR-1:0][AW-1:0]   wr_addr;
  logic [NWR-1:0][XLEN-1:0] wr_data;
  logic                     issue_en;
  logic [AW-1:0]            issue_rd;
  logic [AW:0]              busy_count;

  typedef struct {
    string       name;
    int          kind;
    int          port;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   bypass;

  reg_file_sb #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .NRD   (NRD),
    .NWR   (NWR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .issue_en   (issue_en),
    .issue_rd   (issue_rd),
    .busy_count (busy_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string name, input int kind, input int port, input logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.kind = kind;
    e.port = port;
    e.exp  = exp;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en    = '0;
    wr_addr  = '0;
    wr_data  = '0;
    issue_en = 1'b0;
    issue_rd = '0;
  endtask

  task automatic wr(input int port, input int addr, input logic [31:0] data);
    wr_en[port]   = 1'b1;
    wr_addr[port] = AW'(addr);
    wr_data[port] = data;
  endtask

  task automatic issue(input int addr);
    issue_en = 1'b1;
    issue_rd = AW'(addr);
  endtask

  // Monitor: compares every queued expectation against the settled outputs.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e = q.pop_front();
      case (e.kind)
        K_DATA:  act = rd_data[e.port];
        K_BUSY:  act = {31'b0, rd_busy[e.port]};
        default: act = {26'b0, busy_count};
      endcase
      n_cmp++;
      if (act !== e.exp) begin
        n_bad++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
`ifdef REG_FILE_SB_BYPASS_EN
    bypass = 1'b1;
`else
    bypass = 1'b0;
`endif
    rst     = 1'b1;
    rd_addr = '0;
    idle();
    tick();
    tick();
    rst = 1'b0;

    // Power-on state
    rd_addr[0] = 5'd5;
    rd_addr[1] = 5'd0;
    push("por_data", K_DATA, 0, 32'h0);
    push("por_busy", K_BUSY, 0, 32'h0);
    push("por_count", K_COUNT, 0, 32'h0);

    // Reset mid-operation
    tick();
    wr(0, 5, 32'hDEADBEEF);
    tick();
    idle();
    push("x5_written", K_DATA, 0, 32'hDEADBEEF);
    @(negedge clk);
    #1;
    rst = 1'b1;
    wr(0, 5, 32'h12345678);
    issue(5);
    #1;
    push("rst_async_data", K_DATA, 0, 32'h0);
    push("rst_async_count", K_COUNT, 0, 32'h0);
    push("rst_held_busy", K_BUSY, 0, 32'h0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    idle();
    tick();
    push("post_rst_data", K_DATA, 0, 32'h0);
    push("post_rst_busy", K_BUSY, 0, 32'h0);
    push("post_rst_count", K_COUNT, 0, 32'h0);

    // x0 immunity
    rd_addr[0] = 5'd0;
    wr(0, 0, 32'hFFFFFFFF);
    issue(0);
    tick();
    idle();
    push("x0_data", K_DATA, 0, 32'h0);
    push("x0_busy", K_BUSY, 0, 32'h0);
    push("x0_count", K_COUNT, 0, 32'h0);

    // Write collision: port 1 wins
    rd_addr[1] = 5'd7;
    wr(0, 7, 32'h11);
    wr(1, 7, 32'h22);
    push("collide_same_cycle", K_DATA, 1, bypass ? 32'h22 : 32'h0);
    tick();
    idle();
    push("collide_next", K_DATA, 1, 32'h22);

    // Scoreboard priority
    rd_addr[0] = 5'd3;
    issue(3);
    tick();
    idle();
    push("x3_busy_set", K_BUSY, 0, 32'h1);
    push("x3_count1", K_COUNT, 0, 32'h1);
    issue(3);
    wr(1, 3, 32'h44);
    push("prio_same_data", K_DATA, 0, bypass ? 32'h44 : 32'h0);
    push("prio_same_busy", K_BUSY, 0, 32'h1);
    tick();
    idle();
    push("prio_data", K_DATA, 0, 32'h44);
    push("prio_busy", K_BUSY, 0, 32'h1);
    push("prio_count", K_COUNT, 0, 32'h1);
    wr(0, 3, 32'h55);
    push("clr_same_data", K_DATA, 0, bypass ? 32'h55 : 32'h44);
    push("clr_same_busy", K_BUSY, 0, bypass ? 32'h0 : 32'h1);
    tick();
    idle();
    push("clr_data", K_DATA, 0, 32'h55);
    push("clr_busy", K_BUSY, 0, 32'h0);
    push("clr_count", K_COUNT, 0, 32'h0);

    // Count up to 31 then drain
    for (int r = 1; r < NREGS; r++) begin
      issue(r);
      tick();
      if (r == 16) push("count_16", K_COUNT, 0, 32'd16);
    end
    idle();
    rd_addr[1] = 5'd31;
    push("count_full", K_COUNT, 0, 32'd31);
    push("x31_busy", K_BUSY, 1, 32'h1);
    for (int r = 1; r < NREGS; r++) begin
      idle();
      wr(r % 2, r, 32'(r));
      tick();
      if (r == 10) push("count_drain_21", K_COUNT, 0, 32'd21);
    end
    idle();
    push("count_empty", K_COUNT, 0, 32'd0);
    push("x31_data", K_DATA, 1, 32'd31);
    push("x31_clear", K_BUSY, 1, 32'h0);

    // Read-during-write on x9
    rd_addr[0] = 5'd9;
    wr(0, 9, 32'hABCD);
    push("rdw_data", K_DATA, 0, bypass ? 32'hABCD : 32'd9);
    push("rdw_busy", K_BUSY, 0, 32'h0);
    tick();
    idle();
    push("rdw_next", K_DATA, 0, 32'hABCD);

    @(negedge clk);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
